// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between byte-stream clients.
// A granted client owns the transmitter until its last byte or an idle timeout.
module uart_tx_arbiter #(
    parameter int unsigned NUM_REQUESTERS = 2,
    parameter int unsigned IDLE_TIMEOUT   = 1024,
    localparam int unsigned IW = (NUM_REQUESTERS > 1) ? $clog2(NUM_REQUESTERS) : 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_REQUESTERS-1:0]     req_valid,
    input  logic [8*NUM_REQUESTERS-1:0]   req_data,
    input  logic [NUM_REQUESTERS-1:0]     req_last,
    output logic [NUM_REQUESTERS-1:0]     req_ready,
    output logic [7:0]                    tx_write_data,
    output logic                          tx_write_req,
    input  logic                          tx_ready,
    output logic                          grant_valid,
    output logic [IW-1:0]                 grant_index,
    output logic                          timeout_pulse
);

    localparam int unsigned    CW         = (IDLE_TIMEOUT > 0) ? $clog2(IDLE_TIMEOUT + 1) : 1;
    localparam bit             TIMEOUT_EN = (IDLE_TIMEOUT != 0);
    localparam logic [CW-1:0]  LIMIT      = CW'(IDLE_TIMEOUT);
    localparam logic [IW-1:0]  LAST_INIT  = IW'(NUM_REQUESTERS - 1);

    typedef enum logic {
        ST_IDLE,
        ST_LOCKED
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;

    logic [IW-1:0] winner;
    logic          any_valid;
    int unsigned   scan_idx;
    logic          owner_valid;
    logic          owner_last;

    // Rotating priority search starting just after the previous owner.
    always_comb begin
        winner    = last_q;
        any_valid = 1'b0;
        scan_idx  = 0;
        for (int unsigned k = 1; k <= NUM_REQUESTERS; k++) begin
            scan_idx = (32'(last_q) + k) % NUM_REQUESTERS;
            if (!any_valid && req_valid[scan_idx]) begin
                any_valid = 1'b1;
                winner    = IW'(scan_idx);
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        last_d        = last_q;
        cnt_d         = cnt_q;
        tmo_d         = 1'b0;
        req_ready     = '0;
        tx_write_req  = 1'b0;
        tx_write_data = '0;
        owner_valid   = req_valid[owner_q];
        owner_last    = req_last[owner_q];

        unique case (state_q)
            ST_IDLE: begin
                if (any_valid) begin
                    state_d = ST_LOCKED;
                    owner_d = winner;
                    cnt_d   = '0;
                end
            end
            ST_LOCKED: begin
                req_ready[owner_q] = tx_ready;
                tx_write_data      = req_data[8*32'(owner_q) +: 8];
                tx_write_req       = owner_valid & tx_ready;
                if (owner_valid && tx_ready) begin
                    cnt_d = '0;
                    if (owner_last) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                    end
                end else if (TIMEOUT_EN && tx_ready) begin
                    // Release in the same cycle the count reaches the limit.
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_d == LIMIT) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                        tmo_d   = 1'b1;
                        cnt_d   = '0;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            owner_q <= '0;
            last_q  <= LAST_INIT;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
        end
    end

    assign grant_valid   = (state_q == ST_LOCKED);
    assign grant_index   = owner_q;
    assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: vector table plus multi-cycle sequences.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // Two-client instance with a short timeout
    logic        reset_n;
    logic [1:0]  req_valid;
    logic [15:0] req_data;
    logic [1:0]  req_last;
    logic [1:0]  req_ready;
    logic [7:0]  tx_write_data;
    logic        tx_write_req;
    logic        tx_ready;
    logic        grant_valid;
    logic [0:0]  grant_index;
    logic        timeout_pulse;

    // Three-client instance, timeout disabled
    logic        rst3_n;
    logic [2:0]  valid3;
    logic [23:0] data3;
    logic [2:0]  last3;
    logic [2:0]  ready3;
    logic [7:0]  wdata3;
    logic        wreq3;
    logic        txr3;
    logic        gv3;
    logic [1:0]  gi3;
    logic        tp3;

    uart_tx_arbiter #(.NUM_REQUESTERS(2), .IDLE_TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .tx_write_data(tx_write_data),
        .tx_write_req(tx_write_req), .tx_ready(tx_ready), .grant_valid(grant_valid),
        .grant_index(grant_index), .timeout_pulse(timeout_pulse)
    );

    uart_tx_arbiter #(.NUM_REQUESTERS(3), .IDLE_TIMEOUT(0)) dut3 (
        .clk(clk), .reset_n(rst3_n), .req_valid(valid3), .req_data(data3),
        .req_last(last3), .req_ready(ready3), .tx_write_data(wdata3),
        .tx_write_req(wreq3), .tx_ready(txr3), .grant_valid(gv3),
        .grant_index(gi3), .timeout_pulse(tp3)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n;
        logic [1:0]  valid;
        logic [15:0] data;
        logic [1:0]  last;
        logic        txr;
        logic [1:0]  rdy;
        logic        wreq;
        logic [7:0]  wdata;
        logic        gv;
        logic        gi;
        logic        tp;
    } vec_t;

    localparam int NV = 17;
    vec_t vecs [NV];

    logic [7:0] msg [3];
    int idx, busy, nwr, n3;
    logic wr;
    logic [1:0] exp_gi3;

    initial begin
        // rst, valid, {d1,d0}, last, txr | rdy, wreq, wdata, gv, gi, tp
        vecs[0]  = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 2'b11, 16'h2010, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 2'b11, 16'h2010, 2'b00, 1'b1, 2'b01, 1'b1, 8'h10, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 2'b11, 16'h2011, 2'b01, 1'b0, 2'b00, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 2'b11, 16'h2011, 2'b01, 1'b1, 2'b01, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b1, 2'b11, 16'h2012, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 2'b11, 16'h2012, 2'b00, 1'b1, 2'b10, 1'b1, 8'h20, 1'b1, 1'b1, 1'b0};
        vecs[7]  = '{1'b1, 2'b11, 16'h2112, 2'b10, 1'b1, 2'b10, 1'b1, 8'h21, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b1, 2'b10, 16'h5500, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1'b1, 2'b10, 16'h5500, 2'b00, 1'b1, 2'b10, 1'b1, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{1'b1, 2'b01, 16'h5530, 2'b01, 1'b1, 2'b10, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[11] = '{1'b1, 2'b01, 16'h5530, 2'b01, 1'b1, 2'b10, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{1'b1, 2'b01, 16'h5530, 2'b01, 1'b1, 2'b10, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[13] = '{1'b1, 2'b01, 16'h5530, 2'b01, 1'b1, 2'b10, 1'b0, 8'h55, 1'b1, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 2'b01, 16'h5530, 2'b01, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1};
        vecs[15] = '{1'b1, 2'b01, 16'h5530, 2'b01, 1'b1, 2'b01, 1'b1, 8'h30, 1'b1, 1'b0, 1'b0};
        vecs[16] = '{1'b1, 2'b00, 16'h0000, 2'b00, 1'b1, 2'b00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;

        reset_n = 1'b0; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b1;
        rst3_n = 1'b0; valid3 = '0; data3 = '0; last3 = '0; txr3 = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < NV; i++) begin
            reset_n   = vecs[i].rst_n;
            req_valid = vecs[i].valid;
            req_data  = vecs[i].data;
            req_last  = vecs[i].last;
            tx_ready  = vecs[i].txr;
            @(negedge clk);
            chk($sformatf("v%0d_rdy", i),   req_ready,     vecs[i].rdy);
            chk($sformatf("v%0d_wreq", i),  tx_write_req,  vecs[i].wreq);
            chk($sformatf("v%0d_wdata", i), tx_write_data, vecs[i].wdata);
            chk($sformatf("v%0d_gv", i),    grant_valid,   vecs[i].gv);
            chk($sformatf("v%0d_gi", i),    grant_index,   vecs[i].gi);
            chk($sformatf("v%0d_tp", i),    timeout_pulse, vecs[i].tp);
            @(posedge clk); #1;
        end

        // Three-byte message from client 0 with a slow transmitter
        idx = 0; busy = 0; nwr = 0;
        for (int cyc = 0; cyc < 100 && idx < 3; cyc++) begin
            req_valid = 2'b01;
            req_data  = {8'h00, msg[idx]};
            req_last  = (idx == 2) ? 2'b01 : 2'b00;
            tx_ready  = (busy == 0);
            @(negedge clk);
            if (cyc == 0) chk("msg_grant_lat0", grant_valid, 1'b0);
            if (cyc == 1) chk("msg_grant_lat1", grant_valid, 1'b1);
            wr = tx_write_req;
            if (wr) begin
                chk($sformatf("msg_byte%0d", nwr), tx_write_data, msg[nwr]);
                nwr++;
            end
            @(posedge clk); #1;
            if (wr) begin
                idx++;
                busy = 10;
            end else if (busy > 0) begin
                busy--;
            end
        end
        chk("msg_write_count", nwr, 3);
        req_valid = '0; req_last = '0; tx_ready = 1'b1;
        @(negedge clk);
        chk("msg_end_gv", grant_valid, 1'b0);
        chk("msg_end_rdy", req_ready, 2'b00);
        @(posedge clk); #1;

        // Timeout must not accrue while the transmitter is busy
        req_valid = 2'b10; req_data = 16'h6600; req_last = 2'b00; tx_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_xfer_wreq", tx_write_req, 1'b1);
        chk("hold_xfer_gi", grant_index, 1'b1);
        @(posedge clk); #1;
        req_valid = '0; tx_ready = 1'b0;
        for (int c = 0; c < 50; c++) begin
            @(negedge clk);
            chk($sformatf("hold_busy%0d", c), {grant_valid, timeout_pulse}, 2'b10);
            @(posedge clk); #1;
        end
        tx_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("hold_ready%0d", c), {grant_valid, timeout_pulse}, 2'b10);
            @(posedge clk); #1;
        end
        @(negedge clk);
        chk("hold_release", {grant_valid, timeout_pulse}, 2'b01);
        chk("hold_release_gi", grant_index, 1'b1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("hold_pulse_once", timeout_pulse, 1'b0);
        @(posedge clk); #1;

        // Reset in the middle of a client 1 message
        req_valid = 2'b10; req_data = 16'h7788; req_last = 2'b00; tx_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_pre_gi", grant_index, 1'b1);
        chk("rst_pre_wdata", tx_write_data, 8'h77);
        @(posedge clk); #1;
        reset_n = 1'b0; req_valid = 2'b11;
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(negedge clk);
        chk("rst_gv", grant_valid, 1'b0);
        chk("rst_rdy", req_ready, 2'b00);
        chk("rst_wreq", tx_write_req, 1'b0);
        chk("rst_gi", grant_index, 1'b0);
        chk("rst_tp", timeout_pulse, 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_first_gv", grant_valid, 1'b1);
        chk("rst_first_gi", grant_index, 1'b0);
        chk("rst_first_wdata", tx_write_data, 8'h88);
        @(posedge clk); #1;

        // Three clients requesting continuously rotate 0,1,2,0,1,2
        rst3_n = 1'b1; valid3 = 3'b111; last3 = 3'b111; txr3 = 1'b1;
        data3 = 24'hC2C1C0;
        n3 = 0;
        for (int cyc = 0; cyc < 40 && n3 < 6; cyc++) begin
            @(negedge clk);
            if (wreq3) begin
                exp_gi3 = 2'(n3 % 3);
                chk($sformatf("rr3_gi%0d", n3), gi3, exp_gi3);
                chk($sformatf("rr3_data%0d", n3), wdata3, 8'hC0 + 8'(exp_gi3));
                n3++;
            end
            @(posedge clk); #1;
        end
        chk("rr3_count", n3, 6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Round-robin arbiter that shares one uart_transmitter between NUM_REQUESTERS byte-stream clients.
- A granted client keeps ownership for a whole message, so multi-byte messages are never interleaved on the wire.
- Ownership ends at the byte flagged last, or after an idle timeout.
- Sits between the UART clients (debug console, command response path, ...) and the single transmitter instance; drives its write_data/write_req and observes its ready.

Parameters:
NUM_REQUESTERS, 2, number of client ports (>= 2)
IDLE_TIMEOUT, 1024, idle-cycle limit for a locked owner before forced release; 0 disables timeout

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous, active-low reset
req_valid  input  NUM_REQUESTERS  per-client byte valid
req_data  input  8*NUM_REQUESTERS  per-client byte; client i uses bits [8*i+7:8*i]
req_last  input  NUM_REQUESTERS  per-client last byte of message
req_ready  output  NUM_REQUESTERS  per-client byte accepted this cycle when ANDed with req_valid
tx_write_data  output  8  to uart_transmitter write_data
tx_write_req  output  1  to uart_transmitter write_req
tx_ready  input  1  from uart_transmitter ready (high only when transmitter idle)
grant_valid  output  1  high while a client owns the transmitter
grant_index  output  max(1,$clog2(NUM_REQUESTERS))  current/last owner index
timeout_pulse  output  1  one-cycle pulse on forced release

Behaviour:
- One clock (clk); reset is synchronous and active-low (reset_n); all state updates on posedge clk.
- Reset values: state=IDLE, grant_index=0, grant_valid=0, timeout_pulse=0, idle counter=0.
- Reset: round-robin pointer last_owner=NUM_REQUESTERS-1, so client 0 wins first.
- In IDLE, req_ready=0 and tx_write_req=0 combinationally.
- States:
  - IDLE: winner is the first i with req_valid[i]=1, searching (last_owner+1) mod N upward with wrap.
  - IDLE with any valid: next cycle state=LOCKED, grant_index=winner, grant_valid=1, counter=0.
  - IDLE: no byte moves in the arbitration cycle, giving 1 cycle grant latency.
  - IDLE: if no valid, remain IDLE.
  - LOCKED, owner o: tx_write_data = req_data[o], combinational.
  - LOCKED: tx_write_req = req_valid[o] & tx_ready.
  - LOCKED: req_ready[o] = tx_ready; all other req_ready = 0.
- Transfer = LOCKED & req_valid[o] & tx_ready. Zero-latency pass-through.
  - Transmitter ready drops the cycle after write_req, so there is at most one write per character time.
- Transfer with req_last[o]=1: next state=IDLE, grant_valid=0, last_owner=o. grant_index keeps o.
- Transfer without last: stay LOCKED, counter cleared.
- Idle counter (width $clog2(IDLE_TIMEOUT+1)):
  - Increments on each LOCKED cycle with tx_ready=1 and req_valid[o]=0.
  - Holds while tx_ready=0 (byte in flight).
  - Cleared on transfer and on entry to LOCKED.
- Counter reaching IDLE_TIMEOUT (IDLE_TIMEOUT>0): next state=IDLE, last_owner=o, timeout_pulse=1 for exactly one cycle.
  - The cycle the counter hits the limit is the last LOCKED cycle.
- Simultaneous valid from several clients in IDLE: rotation pointer decides.
- After a release, a waiting different client wins next. A lone client may be re-granted after one IDLE cycle.
- Non-owner valids are ignored while LOCKED, whatever their duration.
- Client rule: valid/data/last held stable until accepted. Not checked.
- Owner drops valid mid-message: no transfer; counter runs.
- tx_ready low on entry to LOCKED: wait; no timeout accrues.
- reset_n low mid-message: next cycle IDLE, all outputs at reset values. Transmitter shares reset_n; the partial message is discarded.

Test Plan:
- Single client 0 sends 3 bytes 0x41,0x42,0x43 (last on 0x43), tx model ready 10 cycles after each write → grant_valid 1 cycle after valid; 3 tx_write_req pulses with those data; IDLE after 0x43.
- Clients 0 and 1 both valid from reset, 2-byte messages each → client 0 message fully, then client 1; bytes never interleaved; grant_index 0 then 1.
- N=3, clients 0,1,2 continuously requesting 1-byte messages → grant order 0,1,2,0,1,2.
- IDLE_TIMEOUT=4: client 1 sends byte 0x55 (last=0), then drops valid, tx_ready=1 → timeout_pulse after 4 idle-ready cycles; grant_valid=0; client 0 granted next if valid.
- Timeout hold: owner silent while tx_ready=0 for 50 cycles → no timeout; counter starts only once tx_ready=1.
- reset_n low for 1 cycle mid-message → next cycle grant_valid=0, req_ready=0, tx_write_req=0; client 0 wins first after reset.
